// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - read-side pointer, flag and CDC control for an async FIFO
//
// Purpose:
//   Owns the read pointer of a dual-clock FIFO. It brings the Gray-coded write
//   pointer into the read domain through a two-flop synchronizer, derives the
//   visible occupancy, and produces the memory read strobe/address plus the
//   empty, almost-empty and underflow status seen by the consumer.
//
// Ports:
//   r_clk          read-domain clock, all state changes on its rising edge
//   rreset         asynchronous active-high reset
//   flush          discard every entry currently visible to the read side
//   rd_enable      consumer read request
//   write_ptr_gray Gray write pointer from the write clock domain (async)
//   fifo_rd_enable memory read strobe (combinational)
//   rd_addr        memory read address, low PTR_WIDTH bits of read_ptr
//   rd_valid       memory data valid, one cycle after fifo_rd_enable
//   empty          registered empty flag
//   almost_empty   occupancy at or below AE_THRESH
//   underflow      one-cycle pulse after a read was rejected because empty
//   rd_count       entries visible to the read side
//   read_ptr       binary read pointer
//   read_ptr_gray  Gray read pointer, handed to the write-domain synchronizer

module fifo_read_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 4,
    parameter int AE_THRESH  = 1
) (
    input  logic                 r_clk,
    input  logic                 rreset,
    input  logic                 flush,
    input  logic                 rd_enable,
    input  logic [PTR_WIDTH:0]   write_ptr_gray,
    output logic                 fifo_rd_enable,
    output logic [PTR_WIDTH-1:0] rd_addr,
    output logic                 rd_valid,
    output logic                 empty,
    output logic                 almost_empty,
    output logic                 underflow,
    output logic [PTR_WIDTH:0]   rd_count,
    output logic [PTR_WIDTH:0]   read_ptr,
    output logic [PTR_WIDTH:0]   read_ptr_gray
);

    // The data word width belongs to the write side; it is only sanity-checked
    // here so both halves of the FIFO share one parameter list.
    if (DATA_WIDTH < 1) begin : g_data_width_check
        $error("fifo_read_ctrl: DATA_WIDTH must be at least 1");
    end

    localparam logic [PTR_WIDTH:0] AE_LIMIT = (PTR_WIDTH+1)'(AE_THRESH);
    localparam logic [PTR_WIDTH:0] PTR_ONE  = {{PTR_WIDTH{1'b0}}, 1'b1};

    function automatic logic [PTR_WIDTH:0] to_gray(input logic [PTR_WIDTH:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Two-flop synchronizer; these are the only flops that see write_ptr_gray.
    logic [PTR_WIDTH:0] wsync1;
    logic [PTR_WIDTH:0] wsync2;

    logic [PTR_WIDTH:0] wbin;
    logic [PTR_WIDTH:0] rptr_next;
    logic [PTR_WIDTH:0] rgray_next;

    // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= PTR_WIDTH; i++) begin
            wbin[i] = ^(wsync2 >> i);
        end
    end

    assign fifo_rd_enable = rd_enable & ~empty & ~flush;

    // Flush jumps straight to the synchronized write pointer, dropping every
    // visible entry in one edge; it wins over a read request.
    always_comb begin
        rptr_next = read_ptr;
        if (flush) begin
            rptr_next = wbin;
        end else if (fifo_rd_enable) begin
            rptr_next = read_ptr + PTR_ONE;
        end
    end

    assign rgray_next = to_gray(rptr_next);

    always_ff @(posedge r_clk or posedge rreset) begin
        if (rreset) begin
            wsync1 <= '0;
            wsync2 <= '0;
        end else begin
            wsync1 <= write_ptr_gray;
            wsync2 <= wsync1;
        end
    end

    // Empty is judged on the pointer being loaded this edge, so reading the
    // last visible entry raises empty on the same edge that advances read_ptr.
    always_ff @(posedge r_clk or posedge rreset) begin
        if (rreset) begin
            read_ptr      <= '0;
            read_ptr_gray <= '0;
            empty         <= 1'b1;
            rd_valid      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            read_ptr      <= rptr_next;
            read_ptr_gray <= rgray_next;
            empty         <= (rgray_next == wsync2);
            rd_valid      <= fifo_rd_enable;
            underflow     <= rd_enable & empty & ~flush;
        end
    end

    assign rd_addr      = read_ptr[PTR_WIDTH-1:0];
    assign rd_count     = wbin - read_ptr;
    assign almost_empty = (rd_count <= AE_LIMIT);

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - directed vector bench for fifo_read_ctrl

module tb_fifo_read_ctrl;

    logic       r_clk = 1'b0;
    logic       rreset = 1'b0;
    logic       flush = 1'b0;
    logic       rd_enable = 1'b0;
    logic [4:0] write_ptr_gray = '0;
    logic       fifo_rd_enable;
    logic [3:0] rd_addr;
    logic       rd_valid;
    logic       empty;
    logic       almost_empty;
    logic       underflow;
    logic [4:0] rd_count;
    logic [4:0] read_ptr;
    logic [4:0] read_ptr_gray;

    int n_vec = 0;
    int n_err = 0;

    fifo_read_ctrl #(.DATA_WIDTH(8), .PTR_WIDTH(4), .AE_THRESH(1)) dut (
        .r_clk          (r_clk),
        .rreset         (rreset),
        .flush          (flush),
        .rd_enable      (rd_enable),
        .write_ptr_gray (write_ptr_gray),
        .fifo_rd_enable (fifo_rd_enable),
        .rd_addr        (rd_addr),
        .rd_valid       (rd_valid),
        .empty          (empty),
        .almost_empty   (almost_empty),
        .underflow      (underflow),
        .rd_count       (rd_count),
        .read_ptr       (read_ptr),
        .read_ptr_gray  (read_ptr_gray)
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        logic       rst;
        logic       fl;
        logic       rd;
        logic [4:0] wpg;
        logic [23:0] exp;
    } vec_t;

    // {fifo_rd_enable, rd_addr, rd_valid, empty, almost_empty, underflow, rd_count, read_ptr, read_ptr_gray}
    function automatic logic [23:0] pk(input logic fre, input logic [3:0] addr, input logic vld,
                                       input logic emp, input logic ae, input logic uf,
                                       input logic [4:0] cnt, input logic [4:0] rp, input logic [4:0] rg);
        return {fre, addr, vld, emp, ae, uf, cnt, rp, rg};
    endfunction

    function automatic logic [23:0] outs();
        return {fifo_rd_enable, rd_addr, rd_valid, empty, almost_empty, underflow,
                rd_count, read_ptr, read_ptr_gray};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    vec_t vecs[16];

    initial begin
        // Inputs applied just after a falling edge; outputs checked 2 ns later,
        // reflecting all earlier rising edges plus the new inputs.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'b00000, pk(0, 0, 0, 1, 1, 0, 0, 0, 0)};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 5'b00001, pk(0, 0, 0, 1, 1, 0, 0, 0, 0)};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 5'b00001, pk(0, 0, 0, 1, 1, 0, 0, 0, 0)};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 5'b00001, pk(0, 0, 0, 1, 1, 0, 1, 0, 0)};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 5'b00001, pk(1, 0, 0, 0, 1, 0, 1, 0, 0)};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 5'b00001, pk(0, 1, 1, 1, 1, 0, 0, 1, 1)};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 5'b00001, pk(0, 1, 0, 1, 1, 1, 0, 1, 1)};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 5'b00011, pk(0, 1, 0, 1, 1, 0, 0, 1, 1)};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 5'b00011, pk(0, 1, 0, 1, 1, 0, 0, 1, 1)};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 5'b00111, pk(0, 1, 0, 1, 1, 0, 1, 1, 1)};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 5'b00111, pk(1, 1, 0, 0, 1, 0, 1, 1, 1)};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 5'b00111, pk(0, 2, 1, 1, 0, 0, 3, 2, 3)};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 5'b00111, pk(0, 5, 0, 1, 1, 0, 0, 5, 7)};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 5'b00111, pk(0, 5, 0, 1, 1, 0, 0, 5, 7)};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 5'b00111, pk(0, 5, 0, 1, 1, 1, 0, 5, 7)};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 5'b00111, pk(0, 5, 0, 1, 1, 0, 0, 5, 7)};

        #1;
        for (int i = 0; i < 16; i++) begin
            rreset         = vecs[i].rst;
            flush          = vecs[i].fl;
            rd_enable      = vecs[i].rd;
            write_ptr_gray = vecs[i].wpg;
            #2;
            chk($sformatf("vec%0d", i), {8'h0, outs()}, {8'h0, vecs[i].exp});
            @(negedge r_clk);
        end

        // Full drain and wrap from a fresh reset, with synchronizer latency.
        rreset = 1'b1; flush = 1'b0; rd_enable = 1'b0; write_ptr_gray = 5'b00000;
        @(negedge r_clk);
        rreset = 1'b0;
        write_ptr_gray = 5'b11000;
        #2;
        chk("lat_k_empty", {31'h0, empty}, 32'd1);
        @(negedge r_clk); #2;
        chk("lat_k1_empty", {31'h0, empty}, 32'd1);
        chk("lat_k1_count", {27'h0, rd_count}, 32'd0);
        @(negedge r_clk); #2;
        chk("lat_k2_empty", {31'h0, empty}, 32'd1);
        chk("lat_k2_count", {27'h0, rd_count}, 32'd16);
        @(negedge r_clk); #2;
        chk("lat_k3_empty", {31'h0, empty}, 32'd0);
        chk("full_ae", {31'h0, almost_empty}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            rd_enable = 1'b1;
            #2;
            chk($sformatf("drain%0d_fre", i), {31'h0, fifo_rd_enable}, 32'd1);
            chk($sformatf("drain%0d_addr", i), {28'h0, rd_addr}, 32'(i));
            chk($sformatf("drain%0d_count", i), {27'h0, rd_count}, 32'(16 - i));
            chk($sformatf("drain%0d_ae", i), {31'h0, almost_empty}, (16 - i) <= 1 ? 32'd1 : 32'd0);
            chk($sformatf("drain%0d_empty", i), {31'h0, empty}, 32'd0);
            @(negedge r_clk);
        end
        rd_enable = 1'b0;
        #2;
        chk("wrap_ptr", {27'h0, read_ptr}, 32'b10000);
        chk("wrap_gray", {27'h0, read_ptr_gray}, 32'b11000);
        chk("wrap_addr", {28'h0, rd_addr}, 32'd0);
        chk("wrap_empty", {31'h0, empty}, 32'd1);
        chk("wrap_count", {27'h0, rd_count}, 32'd0);
        chk("wrap_ae", {31'h0, almost_empty}, 32'd1);
        chk("wrap_valid", {31'h0, rd_valid}, 32'd1);

        // Asynchronous reset in the middle of a read burst.
        write_ptr_gray = 5'b11110;
        repeat (3) @(negedge r_clk);
        #2;
        chk("burst_count", {27'h0, rd_count}, 32'd4);
        rd_enable = 1'b1;
        @(negedge r_clk);
        @(posedge r_clk);
        #2;
        chk("burst_valid", {31'h0, rd_valid}, 32'd1);
        rreset = 1'b1;
        #1;
        chk("arst_state", {8'h0, outs()}, {8'h0, pk(0, 0, 0, 1, 1, 0, 0, 0, 0)});
        @(negedge r_clk);
        rreset = 1'b0;
        rd_enable = 1'b0;
        repeat (2) @(negedge r_clk);
        #2;
        chk("post_reset_count", {27'h0, rd_count}, 32'd20);
        chk("post_reset_ptr", {27'h0, read_ptr}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_read_ctrl.md
FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of the FIFO data word; this block does not use it and keeps it for parameter-list parity with the write side.
REQ-002 SHALL have parameter PTR_WIDTH, default 4, address width; depth is 2^PTR_WIDTH; pointers are PTR_WIDTH+1 bits.
REQ-003 SHALL have parameter AE_THRESH, default 1, almost-empty threshold in entries.
REQ-004 SHALL have port r_clk  input  1  read-domain clock; one clock only; all state changes on its rising edge.
REQ-005 SHALL have port rreset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  input  1  discard all currently visible entries.
REQ-007 SHALL have port rd_enable  input  1  read request from consumer.
REQ-008 SHALL have port write_ptr_gray  input  PTR_WIDTH+1  Gray-coded write pointer from the write clock domain, asynchronous to r_clk.
REQ-009 SHALL have port fifo_rd_enable  output  1  memory read strobe, combinational.
REQ-010 SHALL have port rd_addr  output  PTR_WIDTH  memory read address, equal to read_ptr[PTR_WIDTH-1:0].
REQ-011 SHALL have port rd_valid  output  1  memory data valid, registered.
REQ-012 SHALL have port empty  output  1  FIFO empty, registered.
REQ-013 SHALL have port almost_empty  output  1  occupancy at or below AE_THRESH.
REQ-014 SHALL have port underflow  output  1  one-cycle pulse on a rejected read.
REQ-015 SHALL have port rd_count  output  PTR_WIDTH+1  entries visible to the read side.
REQ-016 SHALL have port read_ptr  output  PTR_WIDTH+1  binary read pointer, registered.
REQ-017 SHALL have port read_ptr_gray  output  PTR_WIDTH+1  Gray read pointer for the write-domain synchronizer, registered.

Function
REQ-018 SHALL pass write_ptr_gray through a two-flop synchronizer (wsync1 then wsync2) clocked by r_clk; no other logic SHALL sample write_ptr_gray.
REQ-019 SHALL convert wsync2 from Gray to binary combinationally (wbin); bit i is the XOR of wsync2 bits PTR_WIDTH down to i.
REQ-020 SHALL drive fifo_rd_enable = rd_enable AND NOT empty AND NOT flush.
REQ-021 SHALL compute rptr_next as follows: wbin when flush; otherwise read_ptr+1 modulo 2^(PTR_WIDTH+1) when fifo_rd_enable; otherwise read_ptr.
REQ-022 SHALL register read_ptr <= rptr_next and read_ptr_gray <= rptr_next XOR (rptr_next >> 1) on every edge.
REQ-023 SHALL register empty <= ((rptr_next XOR (rptr_next >> 1)) == wsync2).
REQ-024 SHALL register rd_valid <= fifo_rd_enable, matching a synchronous memory with one-cycle read latency.
REQ-025 SHALL compute rd_count = (wbin - read_ptr) modulo 2^(PTR_WIDTH+1); the range is 0..2^PTR_WIDTH.
REQ-026 SHALL drive almost_empty = (rd_count <= AE_THRESH).
REQ-027 SHALL register underflow <= rd_enable AND empty AND NOT flush.
REQ-028 SHALL leave the read pointers unchanged on a read while empty.
REQ-029 Flush SHALL take priority over rd_enable; empty SHALL be 1 on the edge after flush, and rd_count SHALL be 0 unless new writes have since become visible.
REQ-030 Wrap-around: rd_addr SHALL go from 2^PTR_WIDTH-1 to 0 while the pointer MSB toggles.
REQ-031 Latency: a write-pointer change that is stable before edge k SHALL appear in wsync2 after edge k+1 and SHALL clear empty after edge k+2.
REQ-032 A read of the last visible entry SHALL set empty on the same edge that advances read_ptr.

Reset
REQ-033 While rreset=1, asynchronously: read_ptr=0, read_ptr_gray=0, wsync1=0, wsync2=0, rd_valid=0, underflow=0, empty=1.
REQ-034 During reset, combinational outputs SHALL follow from the reset state: rd_count=0, almost_empty=1, fifo_rd_enable=0.
REQ-035 Reset SHALL be released synchronously by the integrator; the first active edge after release SHALL operate normally.

Verification (PTR_WIDTH=4, AE_THRESH=1)
REQ-036 Reset: assert rreset -> read_ptr=0, read_ptr_gray=0, empty=1, rd_count=0, rd_valid=0, underflow=0.
REQ-037 Single entry: write_ptr_gray 00000 -> 00001 before edge k -> empty=0 after edge k+2; then rd_enable=1 for one cycle -> fifo_rd_enable=1, rd_addr=0, next edge read_ptr=1, read_ptr_gray=00001, empty=1, rd_valid=1 for one cycle.
REQ-038 Full drain and wrap: write_ptr_gray=11000 (binary 16), rd_count=16 -> 16 back-to-back reads -> rd_addr 0..15, read_ptr=10000, read_ptr_gray=11000, empty=1, almost_empty asserted once rd_count<=1.
REQ-039 Underflow: empty=1 with rd_enable=1 -> fifo_rd_enable=0, read_ptr unchanged, underflow=1 for exactly one cycle.
REQ-040 Flush: wbin=5, read_ptr=2, flush=1 and rd_enable=1 -> fifo_rd_enable=0; next edge read_ptr=5, empty=1, rd_count=0.
REQ-041 Reset mid-read: rreset asserted asynchronously during a read burst -> all registered outputs take their reset values immediately, without waiting for r_clk.
